float_mul_iter: RTL and testbench

FLOAT_MUL_ITER -- requirements
Module: float_mul_iter

---
 rtl/float_pkg.sv | 43 ++++
 rtl/float_mul_iter_if.sv | 25 ++
 rtl/float_round_pack.sv | 59 +++++
 rtl/float_mul_iter.sv | 190 +++++++++++++++++++
 tb/tb_float_mul_iter.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/float_pkg.sv
// float_pkg
// Shared definitions for the iterative floating-point units:
//   state_t   - sequencer states (IDLE, MUL, NORM)
//   bias      - exponent bias for a given exponent width
//   make_inf  - signed infinity pattern, returned in a wide container
//   make_nan  - canonical quiet NaN pattern, returned in a wide container
// Callers size the wide results down to their own word width with a cast.
package float_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      NORM
   } state_t;

   localparam int MAX_W = 64;

   function automatic int bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   // Exponent field all ones and mantissa zero. The sign sits just above the exponent.
   function automatic logic [MAX_W-1:0] make_inf(input int exp_w, input int mant_w, input logic sign);
      logic [MAX_W-1:0] v;
      v = '0;
      for (int i = 0; i < MAX_W; i++) begin
         if (i >= mant_w && i < mant_w + exp_w) begin
            v[i] = 1'b1;
         end
      end
      v[exp_w + mant_w] = sign;
      return v;
   endfunction

   // Quiet NaN: positive sign, exponent all ones, and only the mantissa MSB set.
   function automatic logic [MAX_W-1:0] make_nan(input int exp_w, input int mant_w);
      logic [MAX_W-1:0] v;
      v = make_inf(exp_w, mant_w, 1'b0);
      v[mant_w - 1] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/float_mul_iter_if.sv
// float_mul_iter_if
// Request/result bundle for the iterative multiplier.
//   req   - start request (master -> slave)
//   a, b  - operands {sign, exp, mant} (master -> slave)
//   busy  - unit is not idle (slave -> master)
//   ack   - one-cycle result strobe (slave -> master)
//   out   - product, valid with ack (slave -> master)
//   flags - {invalid, overflow, underflow}, valid with ack (slave -> master)
interface float_mul_iter_if #(
   parameter int EXP_W  = 8,
   parameter int MANT_W = 23
);

   logic                    req;
   logic [EXP_W+MANT_W:0]   a;
   logic [EXP_W+MANT_W:0]   b;
   logic                    busy;
   logic                    ack;
   logic [EXP_W+MANT_W:0]   out;
   logic [2:0]              flags;

   modport master (output req, a, b, input busy, ack, out, flags);
   modport slave  (input req, a, b, output busy, ack, out, flags);

endinterface

// File: rtl/float_round_pack.sv
// float_round_pack
// Combinational normalise / round-to-nearest-even / pack stage.
//   sign      - result sign
//   exp_in    - biased exponent before normalisation (signed, EXP_W+2 bits)
//   sig       - raw significand product in [1,4), binary point below the top two bits
//   result    - packed {sign, exp, mant}; signed inf or signed zero on range errors
//   overflow  - rounded exponent reached the all-ones code
//   underflow - rounded exponent at or below zero (no denormal outputs)
module float_round_pack
   import float_pkg::*;
#(
   parameter int EXP_W  = 8,
   parameter int MANT_W = 23
) (
   input  logic                        sign,
   input  logic signed [EXP_W+1:0]     exp_in,
   input  logic [2*(MANT_W+1)-1:0]     sig,
   output logic [EXP_W+MANT_W:0]       result,
   output logic                        overflow,
   output logic                        underflow
);

   localparam int W  = 1 + EXP_W + MANT_W;
   localparam int M  = MANT_W + 1;
   localparam int PW = 2 * M;
   localparam logic signed [EXP_W+1:0] EXP_MAX = (EXP_W+2)'((1 << EXP_W) - 1);

   logic                     carry;
   logic [PW-2:0]            norm;
   logic [MANT_W-1:0]        mant;
   logic                     guard;
   logic                     sticky;
   logic                     round_up;
   logic [MANT_W:0]          mant_r;
   logic signed [EXP_W+1:0]  exp_r;

   // The hidden one lands at the top of norm after a shift of at most one place.
   // A rounding carry out of the mantissa leaves an all-zero mantissa and bumps the exponent.
   always_comb begin
      carry     = sig[PW-1];
      norm      = carry ? sig[PW-2:0] : {sig[PW-3:0], 1'b0};
      mant      = norm[PW-2 -: MANT_W];
      guard     = norm[M-1];
      sticky    = |norm[M-2:0];
      round_up  = guard & (sticky | mant[0]);
      mant_r    = {1'b0, mant} + {{MANT_W{1'b0}}, round_up};
      exp_r     = exp_in + (EXP_W+2)'(carry) + (EXP_W+2)'(mant_r[MANT_W]);
      overflow  = !exp_r[EXP_W+1] && (exp_r >= EXP_MAX);
      underflow = exp_r[EXP_W+1] || (exp_r == '0);
      if (overflow) begin
         result = W'(make_inf(EXP_W, MANT_W, sign));
      end else if (underflow) begin
         result = {sign, {(W-1){1'b0}}};
      end else begin
         result = {sign, exp_r[EXP_W-1:0], mant_r[MANT_W-1:0]};
      end
   end

endmodule

// File: rtl/float_mul_iter.sv
// float_mul_iter
// Iterative floating-point multiplier, BITS_PER_CYCLE multiplier bits per MUL cycle.
//   clk  - rising-edge clock
//   rst  - asynchronous, active-low reset
//   bus  - slave side of float_mul_iter_if (req, a, b in; busy, ack, out, flags out)
// Zero, infinity and NaN operands finish straight from IDLE with ack one cycle later;
// finite non-zero operands run N = (MANT_W+1)/BITS_PER_CYCLE MUL cycles then one NORM cycle.
module float_mul_iter
   import float_pkg::*;
#(
   parameter int EXP_W          = 8,
   parameter int MANT_W         = 23,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic               clk,
   input  logic               rst,
   float_mul_iter_if.slave    bus
);

   localparam int W     = 1 + EXP_W + MANT_W;
   localparam int M     = MANT_W + 1;
   localparam int PW    = 2 * M;
   localparam int K     = BITS_PER_CYCLE;
   localparam int N     = M / K;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic signed [EXP_W+1:0] BIAS_S = (EXP_W+2)'(bias(EXP_W));

   state_t                   state;
   state_t                   state_n;
   logic [CNT_W-1:0]         count;
   logic [M-1:0]             a_mant;
   logic [M-1:0]             b_mant;
   logic [EXP_W-1:0]         a_exp;
   logic [EXP_W-1:0]         b_exp;
   logic                     sign;
   logic [PW-1:0]            acc;
   logic                     busy_q;
   logic                     ack_q;
   logic [W-1:0]             out_q;
   logic [2:0]               flags_q;

   logic                     a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
   logic                     special;
   logic                     invalid;
   logic                     in_sign;
   logic [W-1:0]             special_out;
   logic [2:0]               special_flags;
   logic                     load;
   logic                     special_done;
   logic                     step;
   logic                     finish;
   logic                     last_step;
   logic [K-1:0]             b_slice;
   logic [PW-1:0]            partial;
   logic signed [EXP_W+1:0]  exp_sum;
   logic [W-1:0]             rp_result;
   logic                     rp_ovf;
   logic                     rp_unf;

   // Operand classification; exp field zero is treated as zero, so denormals flush.
   always_comb begin
      a_zero  = (bus.a[W-2:MANT_W] == '0);
      b_zero  = (bus.b[W-2:MANT_W] == '0);
      a_nan   = (&bus.a[W-2:MANT_W]) && (|bus.a[MANT_W-1:0]);
      b_nan   = (&bus.b[W-2:MANT_W]) && (|bus.b[MANT_W-1:0]);
      a_inf   = (&bus.a[W-2:MANT_W]) && !(|bus.a[MANT_W-1:0]);
      b_inf   = (&bus.b[W-2:MANT_W]) && !(|bus.b[MANT_W-1:0]);
      in_sign = bus.a[W-1] ^ bus.b[W-1];
      special = a_zero | b_zero | (&bus.a[W-2:MANT_W]) | (&bus.b[W-2:MANT_W]);
      invalid = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
      if (invalid) begin
         special_out   = W'(make_nan(EXP_W, MANT_W));
         special_flags = 3'b100;
      end else if (a_inf | b_inf) begin
         special_out   = W'(make_inf(EXP_W, MANT_W, in_sign));
         special_flags = 3'b000;
      end else begin
         special_out   = {in_sign, {(W-1){1'b0}}};
         special_flags = 3'b000;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state logic; req is only looked at in IDLE.
   always_comb begin
      state_n   = state;
      last_step = (count == CNT_W'(N - 1));
      case (state)
         IDLE: if (bus.req && !special) state_n = MUL;
         MUL:  if (last_step) state_n = NORM;
         NORM: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Per-state control strobes for the datapath.
   always_comb begin
      load         = 1'b0;
      special_done = 1'b0;
      step         = 1'b0;
      finish       = 1'b0;
      case (state)
         IDLE: begin
            load         = bus.req && !special;
            special_done = bus.req && special;
         end
         MUL:  step   = 1'b1;
         NORM: finish = 1'b1;
         default: ;
      endcase
   end

   // Partial product for this MUL cycle: A times the next K-bit chunk of B, weighted by position.
   always_comb begin
      b_slice = K'(b_mant >> (int'(count) * K));
      partial = (PW'(a_mant) * PW'(b_slice)) << (int'(count) * K);
      exp_sum = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - BIAS_S;
   end

   float_round_pack #(
      .EXP_W  (EXP_W),
      .MANT_W (MANT_W)
   ) u_round_pack (
      .sign      (sign),
      .exp_in    (exp_sum),
      .sig       (acc),
      .result    (rp_result),
      .overflow  (rp_ovf),
      .underflow (rp_unf)
   );

   // Datapath and registered outputs; out/flags read zero whenever ack is low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count   <= '0;
         a_mant  <= '0;
         b_mant  <= '0;
         a_exp   <= '0;
         b_exp   <= '0;
         sign    <= 1'b0;
         acc     <= '0;
         busy_q  <= 1'b0;
         ack_q   <= 1'b0;
         out_q   <= '0;
         flags_q <= '0;
      end else begin
         busy_q  <= (state_n != IDLE);
         ack_q   <= 1'b0;
         out_q   <= '0;
         flags_q <= '0;
         if (load) begin
            a_mant <= {1'b1, bus.a[MANT_W-1:0]};
            b_mant <= {1'b1, bus.b[MANT_W-1:0]};
            a_exp  <= bus.a[W-2:MANT_W];
            b_exp  <= bus.b[W-2:MANT_W];
            sign   <= in_sign;
            acc    <= '0;
            count  <= '0;
         end
         if (special_done) begin
            ack_q   <= 1'b1;
            out_q   <= special_out;
            flags_q <= special_flags;
         end
         if (step) begin
            acc   <= acc + partial;
            count <= last_step ? '0 : count + 1'b1;
         end
         if (finish) begin
            ack_q   <= 1'b1;
            out_q   <= rp_result;
            flags_q <= {1'b0, rp_ovf, rp_unf};
         end
      end
   end

   assign bus.busy  = busy_q;
   assign bus.ack   = ack_q;
   assign bus.out   = out_q;
   assign bus.flags = flags_q;

endmodule

// File: tb/tb_float_mul_iter.sv
// tb_float_mul_iter
// Directed bench for float_mul_iter: one K=1 and one K=4 instance run the same vectors,
// with expected products, flags and ack latencies worked out by hand.
module tb_float_mul_iter;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   float_mul_iter_if #(.EXP_W(8), .MANT_W(23)) bus1 ();
   float_mul_iter_if #(.EXP_W(8), .MANT_W(23)) bus4 ();

   float_mul_iter #(.EXP_W(8), .MANT_W(23), .BITS_PER_CYCLE(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   float_mul_iter #(.EXP_W(8), .MANT_W(23), .BITS_PER_CYCLE(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4)
   );

   int          testCount = 0;
   int          failCount = 0;
   int          lat1, lat4;
   logic [31:0] res1, res4;
   logic [2:0]  flg1, flg4;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Drives one request into both units and records when each acks and what it returned.
   // Operands are scrambled after the sampling edge to show only that edge matters.
   task automatic applyStimulus(input logic [31:0] opA, input logic [31:0] opB);
      lat1 = -1; lat4 = -1;
      res1 = '0; res4 = '0; flg1 = '0; flg4 = '0;
      @(negedge clk);
      bus1.req = 1'b1; bus1.a = opA; bus1.b = opB;
      bus4.req = 1'b1; bus4.a = opA; bus4.b = opB;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         #1;
         if (c == 1) begin
            bus1.req = 1'b0; bus1.a = 32'hDEADBEEF; bus1.b = 32'h12345678;
            bus4.req = 1'b0; bus4.a = 32'hDEADBEEF; bus4.b = 32'h12345678;
         end
         if (lat1 < 0 && bus1.ack) begin
            lat1 = c; res1 = bus1.out; flg1 = bus1.flags;
         end
         if (lat4 < 0 && bus4.ack) begin
            lat4 = c; res4 = bus4.out; flg4 = bus4.flags;
         end
         if (lat1 >= 0 && lat4 >= 0) break;
      end
      @(negedge clk);
   endtask

   task automatic runCase(input string tag, input logic [31:0] opA, input logic [31:0] opB,
                          input logic [31:0] expOut, input logic [2:0] expFlags,
                          input int expLat1, input int expLat4);
      applyStimulus(opA, opB);
      checkOutput({tag, "_out_k1"},   res1,       expOut);
      checkOutput({tag, "_flags_k1"}, 32'(flg1),  32'(expFlags));
      checkOutput({tag, "_lat_k1"},   32'(lat1),  32'(expLat1));
      checkOutput({tag, "_out_k4"},   res4,       expOut);
      checkOutput({tag, "_flags_k4"}, 32'(flg4),  32'(expFlags));
      checkOutput({tag, "_lat_k4"},   32'(lat4),  32'(expLat4));
   endtask

   initial begin
      int ackCount;
      int lat;
      logic [31:0] res;

      rst = 1'b0;
      bus1.req = 1'b0; bus1.a = '0; bus1.b = '0;
      bus4.req = 1'b0; bus4.a = '0; bus4.b = '0;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_busy",  32'(bus1.busy),  32'd0);
      checkOutput("rst_ack",   32'(bus1.ack),   32'd0);
      checkOutput("rst_out",   bus1.out,        32'd0);
      checkOutput("rst_flags", 32'(bus1.flags), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // 1.5 * 2 = 3
      runCase("basic",    32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000, 26, 8);
      // -1.5 * 2 = -3
      runCase("neg",      32'hBFC00000, 32'h40000000, 32'hC0400000, 3'b000, 26, 8);
      // (1+u)^2 = 1 + 2u + u^2, below half ulp discarded
      runCase("round",    32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000, 26, 8);
      // 1.5*(1+u) = 1.5 + u + u/2: exact tie, odd LSB rounds up
      runCase("tie_up",   32'h3F800001, 32'h3FC00000, 32'h3FC00002, 3'b000, 26, 8);
      // 1.5*(1+3u) = 1.5 + 4u + u/2: exact tie, even LSB stays
      runCase("tie_even", 32'h3F800003, 32'h3FC00000, 32'h3FC00004, 3'b000, 26, 8);
      // Specials finish from IDLE
      runCase("zero",     32'h00000000, 32'hC0000000, 32'h80000000, 3'b000, 1, 1);
      runCase("inf_zero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b100, 1, 1);
      runCase("inf_neg",  32'h7F800000, 32'hC0000000, 32'hFF800000, 3'b000, 1, 1);
      runCase("nan",      32'h7F800123, 32'h3F800000, 32'h7FC00000, 3'b100, 1, 1);
      // Range errors
      runCase("ovf",      32'h7F000000, 32'h40000000, 32'h7F800000, 3'b010, 26, 8);
      runCase("unf",      32'h00800000, 32'h00800000, 32'h00000000, 3'b001, 26, 8);

      // A req pulsed on the fifth busy cycle is ignored: one ack, first operation's result.
      ackCount = 0; lat = -1; res = '0;
      @(negedge clk);
      bus1.req = 1'b1; bus1.a = 32'h3FC00000; bus1.b = 32'h40000000;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         #1;
         if (c == 1) bus1.req = 1'b0;
         if (c == 5) begin
            bus1.req = 1'b1; bus1.a = 32'h40000000; bus1.b = 32'h40000000;
         end
         if (c == 6) bus1.req = 1'b0;
         if (bus1.ack) begin
            ackCount++;
            if (lat < 0) begin
               lat = c; res = bus1.out;
            end
         end
      end
      checkOutput("ignore_ackcount", 32'(ackCount), 32'd1);
      checkOutput("ignore_lat",      32'(lat),      32'd26);
      checkOutput("ignore_out",      res,           32'h40400000);

      // Back-to-back: a new req presented while ack is high.
      lat = -1; res = '0;
      @(negedge clk);
      bus1.req = 1'b1; bus1.a = 32'h3FC00000; bus1.b = 32'h40000000;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         #1;
         if (c == 1) bus1.req = 1'b0;
         if (bus1.ack) begin
            lat = c;
            break;
         end
      end
      checkOutput("b2b_first_lat", 32'(lat), 32'd26);
      bus1.req = 1'b1; bus1.a = 32'hBFC00000; bus1.b = 32'h40000000;
      lat = -1;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         #1;
         if (c == 1) bus1.req = 1'b0;
         if (bus1.ack) begin
            lat = c; res = bus1.out;
            break;
         end
      end
      checkOutput("b2b_second_lat", 32'(lat), 32'd26);
      checkOutput("b2b_second_out", res,      32'hC0400000);

      // Reset mid-MUL: outputs clear at once and the aborted operation never acks.
      @(negedge clk);
      bus1.req = 1'b1; bus1.a = 32'h3FC00000; bus1.b = 32'h40000000;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk);
         #1;
         if (c == 1) bus1.req = 1'b0;
      end
      checkOutput("midrst_busy_before", 32'(bus1.busy), 32'd1);
      rst = 1'b0;
      #1;
      checkOutput("midrst_busy", 32'(bus1.busy), 32'd0);
      checkOutput("midrst_ack",  32'(bus1.ack),  32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      ackCount = 0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         #1;
         if (bus1.ack) ackCount++;
      end
      checkOutput("midrst_no_ack", 32'(ackCount), 32'd0);

      // A fresh request after reset completes normally.
      runCase("after_rst", 32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000, 26, 8);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
